// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Supplies default ADDR_WIDTH/DATA_WIDTH macros when the build does not define them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // A single requester still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (wrapping) for the first active request.
// grant is gated by en; idx reports the winner even when en is low.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                req,
  input  logic                              en,
  input  logic [idx_width(NUM_REQ)-1:0]     ptr,
  output logic [NUM_REQ-1:0]                grant,
  output logic [idx_width(NUM_REQ)-1:0]     idx
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = en;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master sharing one bus between NUM_REQ requesters with round-robin arbitration.
// Optional PREADY timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = `DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET_N,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic                            PWRITE,
  output logic                            PSEL,
  output logic                            PENABLE,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            PREADY
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  if (NUM_REQ < 1) begin : g_bad_num_req
    $error("NUM_REQ must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic            accept_en;
  logic            accept;
  logic            complete;
  logic            abort;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .en    (accept_en),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign accept_en = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
  assign accept    = |arb_grant;
  assign req_ready = arb_grant;
  assign complete  = (state_q == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      tcnt_q <= '0;
    end else if ((state_q == ACCESS) && !PREADY) begin
      tcnt_q <= tcnt_q + TW'(1);
    end else begin
      tcnt_q <= '0;
    end
  end

  // Abort pulses on the TIMEOUT_CYCLES-th consecutive PREADY-low ACCESS cycle.
  assign abort = (state_q == ACCESS) && !PREADY && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (complete) begin
          rsp_valid[gidx_q] = 1'b1;
          rsp_rdata         = PWRITE ? '0 : PRDATA;
          state_d           = accept ? SETUP : IDLE;
        end else if (abort) begin
          rsp_valid[gidx_q] = 1'b1;
          rsp_err           = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q  <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
        gidx_q <= arb_idx;
        PADDR  <= req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
        PWDATA <= req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        PWRITE <= req_write[arb_idx];
      end
    end
  end

endmodule
